// File: rtl/trig_pulse_sched.sv
// Multi-channel timestamp-driven pulse scheduler: 2-stage delay adder, per-channel due-time FIFOs and pulse generators.
// Define TRIG_SCHED_STATS_EN to build the per-channel fired/missed/overflow statistics counters.
module trig_pulse_sched #(
    parameter int g_num_channels   = 4,
    parameter int g_fifo_depth     = 16,
    parameter int g_coarse_bits    = 28,
    parameter int g_cycles_per_sec = 125000000,
    parameter int g_width_bits     = 8
) (
    input  logic                                                            clk_sys_i,
    input  logic                                                            rst_i,
    input  logic [g_coarse_bits-1:0]                                        tm_cycles_i,
    input  logic                                                            tm_valid_i,
    input  logic                                                            trig_valid_i,
    input  logic [((g_num_channels > 1) ? $clog2(g_num_channels) : 1)-1:0] trig_ch_i,
    input  logic [g_coarse_bits-1:0]                                        trig_cycles_i,
    input  logic [g_num_channels-1:0]                                       enable_i,
    input  logic [g_num_channels*g_coarse_bits-1:0]                         delay_i,
    input  logic [g_num_channels*g_width_bits-1:0]                          width_i,
    output logic [g_num_channels-1:0]                                       pulse_o,
    output logic [g_num_channels-1:0]                                       fifo_full_o,
    input  logic                                                            stat_clr_i,
    output logic [g_num_channels*16-1:0]                                    stat_fired_o,
    output logic [g_num_channels*16-1:0]                                    stat_missed_o,
    output logic [g_num_channels*16-1:0]                                    stat_ovf_o
);
    localparam int              CH_W   = (g_num_channels > 1) ? $clog2(g_num_channels) : 1;
    localparam int              AW     = $clog2(g_fifo_depth);
    localparam int              CB     = g_coarse_bits;
    localparam logic [CB:0]     CPS    = (CB+1)'(g_cycles_per_sec);
    localparam logic [CB:0]     HALF   = CPS >> 1;
    localparam logic [AW:0]     DEPTH  = (AW+1)'(g_fifo_depth);
    localparam logic [CH_W:0]   NUM_CH = (CH_W+1)'(g_num_channels);

    logic [CB-1:0]           delay_s [g_num_channels];
    logic [g_width_bits-1:0] width_s [g_num_channels];
    logic                    ch_ok_s;
    logic                    s1_vld_r;
    logic [CH_W-1:0]         s1_ch_r;
    logic [CB:0]             s1_sum_r;
    logic [CB-1:0]           s2_due_s;
    logic                    s2_vld_r;
    logic [CH_W-1:0]         s2_ch_r;
    logic [CB-1:0]           s2_due_r;

    assign ch_ok_s = ({1'b0, trig_ch_i} < NUM_CH);

    // Ingress stage 1: qualify the strobe and add the channel's coarse delay
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            s1_vld_r <= 1'b0;
            s1_ch_r  <= {CH_W{1'b0}};
            s1_sum_r <= {(CB+1){1'b0}};
        end else begin
            s1_vld_r <= trig_valid_i && ch_ok_s && enable_i[trig_ch_i];
            s1_ch_r  <= trig_ch_i;
            s1_sum_r <= {1'b0, trig_cycles_i} + {1'b0, delay_s[trig_ch_i]};
        end
    end

    // Fold the sum back into the current second
    always_comb begin
        if (s1_sum_r >= CPS) begin
            s2_due_s = CB'(s1_sum_r - CPS);
        end else begin
            s2_due_s = s1_sum_r[CB-1:0];
        end
    end

    // Ingress stage 2: holds the due time for the push; a channel disabled meanwhile loses it
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            s2_vld_r <= 1'b0;
            s2_ch_r  <= {CH_W{1'b0}};
            s2_due_r <= {CB{1'b0}};
        end else begin
            s2_vld_r <= s1_vld_r && enable_i[s1_ch_r];
            s2_ch_r  <= s1_ch_r;
            s2_due_r <= s2_due_s;
        end
    end

`ifndef TRIG_SCHED_STATS_EN
    logic stat_clr_unused_s;
    assign stat_clr_unused_s = stat_clr_i;
`endif

    for (genvar c = 0; c < g_num_channels; c++) begin : g_ch
        localparam logic [CH_W-1:0] MY_CH = CH_W'(c);

        logic [CB-1:0]           mem_r [g_fifo_depth];
        logic [AW-1:0]           wr_ptr_r;
        logic [AW-1:0]           rd_ptr_r;
        logic [AW:0]             count_r;
        logic [AW:0]             count_s;
        logic                    full_r;
        logic                    full_s;
        logic                    push_req_s;
        logic                    push_s;
        logic                    pop_s;
        logic                    fire_s;
        logic                    late_s;
        logic [CB-1:0]           head_s;
        logic [CB:0]             diff_s;
        logic [g_width_bits-1:0] wlen_s;
        logic [g_width_bits-1:0] cnt_r;
        logic [g_width_bits-1:0] cnt_s;
        logic                    pulse_r;

        assign delay_s[c]  = delay_i[c*CB +: CB];
        assign width_s[c]  = width_i[c*g_width_bits +: g_width_bits];
        assign full_s      = (count_r == DEPTH);
        assign push_req_s  = s2_vld_r && (s2_ch_r == MY_CH) && enable_i[c];
        assign push_s      = push_req_s && !full_s;
        assign pop_s       = fire_s || late_s;
        assign count_s     = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        assign pulse_o[c]     = pulse_r;
        assign fifo_full_o[c] = full_r;

        // Head classification: modular distance to the due time decides FIRE, LATE or WAIT
        always_comb begin
            head_s = mem_r[rd_ptr_r];
            fire_s = 1'b0;
            late_s = 1'b0;
            if (head_s >= tm_cycles_i) begin
                diff_s = {1'b0, head_s} - {1'b0, tm_cycles_i};
            end else begin
                diff_s = {1'b0, head_s} + CPS - {1'b0, tm_cycles_i};
            end
            if (enable_i[c] && tm_valid_i && (count_r != {(AW+1){1'b0}})) begin
                if (diff_s == {(CB+1){1'b0}}) begin
                    fire_s = 1'b1;
                end else if (diff_s > HALF) begin
                    late_s = 1'b1;
                end else begin
                    fire_s = 1'b0;
                end
            end else begin
                late_s = 1'b0;
            end
        end

        // FIFO storage, written on accepted pushes only
        always_ff @(posedge clk_sys_i) begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= s2_due_r;
            end
        end

        // FIFO pointers; a disabled channel is held flushed
        always_ff @(posedge clk_sys_i) begin
            if (rst_i || !enable_i[c]) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
                count_r  <= {(AW+1){1'b0}};
                full_r   <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                count_r <= count_s;
                full_r  <= (count_s == DEPTH);
            end
        end

        // Remaining pulse length; FIRE reloads it so a retrigger extends without a gap
        always_comb begin
            if (width_s[c] == {g_width_bits{1'b0}}) begin
                wlen_s = {{(g_width_bits-1){1'b0}}, 1'b1};
            end else begin
                wlen_s = width_s[c];
            end
            if (fire_s) begin
                cnt_s = wlen_s;
            end else if (cnt_r != {g_width_bits{1'b0}}) begin
                cnt_s = cnt_r - {{(g_width_bits-1){1'b0}}, 1'b1};
            end else begin
                cnt_s = {g_width_bits{1'b0}};
            end
        end

        // Pulse output register
        always_ff @(posedge clk_sys_i) begin
            if (rst_i || !enable_i[c]) begin
                cnt_r   <= {g_width_bits{1'b0}};
                pulse_r <= 1'b0;
            end else begin
                cnt_r   <= cnt_s;
                pulse_r <= (cnt_s != {g_width_bits{1'b0}});
            end
        end

`ifdef TRIG_SCHED_STATS_EN
        logic        ovf_s;
        logic [15:0] fired_r;
        logic [15:0] missed_r;
        logic [15:0] ovf_r;

        assign ovf_s = push_req_s && full_s;

        // Saturating event counters; clear wins over a same-cycle increment
        always_ff @(posedge clk_sys_i) begin
            if (rst_i || stat_clr_i) begin
                fired_r  <= 16'd0;
                missed_r <= 16'd0;
                ovf_r    <= 16'd0;
            end else begin
                if (fire_s && (fired_r != 16'hFFFF)) begin
                    fired_r <= fired_r + 16'd1;
                end
                if (late_s && (missed_r != 16'hFFFF)) begin
                    missed_r <= missed_r + 16'd1;
                end
                if (ovf_s && (ovf_r != 16'hFFFF)) begin
                    ovf_r <= ovf_r + 16'd1;
                end
            end
        end

        assign stat_fired_o[c*16 +: 16]  = fired_r;
        assign stat_missed_o[c*16 +: 16] = missed_r;
        assign stat_ovf_o[c*16 +: 16]    = ovf_r;
`else
        assign stat_fired_o[c*16 +: 16]  = 16'd0;
        assign stat_missed_o[c*16 +: 16] = 16'd0;
        assign stat_ovf_o[c*16 +: 16]    = 16'd0;
`endif
    end

endmodule

// File: tb/tb_trig_pulse_sched.sv
// Bench for trig_pulse_sched: directed scenarios plus random traffic against a queue-based reference model.
module tb_trig_pulse_sched;
    localparam int          NCH   = 4;
    localparam int          DEPTH = 16;
    localparam int          CB    = 28;
    localparam int          WB    = 8;
    localparam int unsigned M     = 125000000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [CB-1:0]       tm = '0;
    logic                tm_valid = 1'b1;
    logic                trig_valid = 1'b0;
    logic [1:0]          trig_ch = '0;
    logic [CB-1:0]       trig_cycles = '0;
    logic [NCH-1:0]      enable = '1;
    logic [NCH*CB-1:0]   delay = '0;
    logic [NCH*WB-1:0]   width = '0;
    logic                stat_clr = 1'b0;
    logic [NCH-1:0]      pulse;
    logic [NCH-1:0]      fifo_full;
    logic [NCH*16-1:0]   st_fired;
    logic [NCH*16-1:0]   st_missed;
    logic [NCH*16-1:0]   st_ovf;

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned q [NCH][$];
    int          inf_ch [$];
    int unsigned inf_due [$];
    int          inf_at [$];
    int          pulse_end [NCH];
    int          m_fired [NCH];
    int          m_missed [NCH];
    int          m_ovf [NCH];
    int          n = 0;
    int unsigned cur_tm = 0;

    // observation counters
    int             hi_cnt [NCH];
    int             rises [NCH];
    logic [NCH-1:0] prev_p = '0;

    trig_pulse_sched dut (
        .clk_sys_i     (clk),
        .rst_i         (rst),
        .tm_cycles_i   (tm),
        .tm_valid_i    (tm_valid),
        .trig_valid_i  (trig_valid),
        .trig_ch_i     (trig_ch),
        .trig_cycles_i (trig_cycles),
        .enable_i      (enable),
        .delay_i       (delay),
        .width_i       (width),
        .pulse_o       (pulse),
        .fifo_full_o   (fifo_full),
        .stat_clr_i    (stat_clr),
        .stat_fired_o  (st_fired),
        .stat_missed_o (st_missed),
        .stat_ovf_o    (st_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int wid(input int c);
        int w;
        w = int'(width[c*WB +: WB]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_edge();
        int          pre;
        longint      diff;
        int unsigned d;
        n++;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                q[c].delete();
                pulse_end[c] = -1;
                m_fired[c] = 0;
                m_missed[c] = 0;
                m_ovf[c] = 0;
            end
            inf_ch.delete();
            inf_due.delete();
            inf_at.delete();
            return;
        end
        for (int i = inf_ch.size() - 1; i >= 0; i--) begin
            if (!enable[inf_ch[i]]) begin
                inf_ch.delete(i);
                inf_due.delete(i);
                inf_at.delete(i);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!enable[c]) begin
                q[c].delete();
                pulse_end[c] = -1;
                continue;
            end
            pre = q[c].size();
            if (tm_valid && pre > 0) begin
                diff = ((longint'(q[c][0]) - longint'(tm)) % longint'(M) + longint'(M)) % longint'(M);
                if (diff == 0) begin
                    pulse_end[c] = n + wid(c) - 1;
                    if (m_fired[c] < 65535) m_fired[c]++;
                    void'(q[c].pop_front());
                end else if (diff > longint'(M / 2)) begin
                    if (m_missed[c] < 65535) m_missed[c]++;
                    void'(q[c].pop_front());
                end
            end
            for (int i = 0; i < inf_ch.size(); i++) begin
                if (inf_ch[i] == c && inf_at[i] == n) begin
                    if (pre >= DEPTH) begin
                        if (m_ovf[c] < 65535) m_ovf[c]++;
                    end else begin
                        q[c].push_back(inf_due[i]);
                    end
                end
            end
        end
        for (int i = inf_ch.size() - 1; i >= 0; i--) begin
            if (inf_at[i] == n) begin
                inf_ch.delete(i);
                inf_due.delete(i);
                inf_at.delete(i);
            end
        end
        if (trig_valid && enable[trig_ch]) begin
            d = int'(delay[int'(trig_ch)*CB +: CB]);
            inf_ch.push_back(int'(trig_ch));
            inf_due.push_back(int'((longint'(trig_cycles) + longint'(d)) % longint'(M)));
            inf_at.push_back(n + 2);
        end
        if (stat_clr) begin
            for (int c = 0; c < NCH; c++) begin
                m_fired[c] = 0;
                m_missed[c] = 0;
                m_ovf[c] = 0;
            end
        end
    endtask

    task automatic step();
        logic [NCH-1:0]    exp_p;
        logic [NCH-1:0]    exp_f;
        logic [NCH*16-1:0] ef;
        logic [NCH*16-1:0] em;
        logic [NCH*16-1:0] eo;
        @(posedge clk);
        model_edge();
        #1;
        ef = '0;
        em = '0;
        eo = '0;
        for (int c = 0; c < NCH; c++) begin
            exp_p[c] = (pulse_end[c] >= n);
            exp_f[c] = (q[c].size() == DEPTH);
`ifdef TRIG_SCHED_STATS_EN
            ef[c*16 +: 16] = 16'(m_fired[c]);
            em[c*16 +: 16] = 16'(m_missed[c]);
            eo[c*16 +: 16] = 16'(m_ovf[c]);
`endif
        end
        check_val("pulse", 64'(pulse), 64'(exp_p));
        check_val("full", 64'(fifo_full), 64'(exp_f));
        check_val("st_fired", 64'(st_fired), 64'(ef));
        check_val("st_missed", 64'(st_missed), 64'(em));
        check_val("st_ovf", 64'(st_ovf), 64'(eo));
        for (int c = 0; c < NCH; c++) begin
            if (pulse[c] === 1'b1) hi_cnt[c]++;
            if (pulse[c] === 1'b1 && prev_p[c] !== 1'b1) rises[c]++;
        end
        prev_p = pulse;
        trig_valid = 1'b0;
        cur_tm = (cur_tm + 1) % M;
        tm = cur_tm[CB-1:0];
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic set_tm(input int unsigned v);
        cur_tm = v;
        tm = v[CB-1:0];
    endtask

    task automatic set_ch(input int c, input int unsigned d, input int unsigned w);
        delay[c*CB +: CB] = d[CB-1:0];
        width[c*WB +: WB] = w[WB-1:0];
    endtask

    task automatic strobe(input int c, input int unsigned t);
        trig_valid = 1'b1;
        trig_ch = 2'(c);
        trig_cycles = t[CB-1:0];
        step();
    endtask

    task automatic clr_obs();
        for (int c = 0; c < NCH; c++) begin
            hi_cnt[c] = 0;
            rises[c] = 0;
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            pulse_end[c] = -1;
            set_ch(c, 0, 1);
        end
        clr_obs();
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        check_val("rst_pulse", 64'(pulse), 64'd0);
        check_val("rst_full", 64'(fifo_full), 64'd0);

        // delayed trigger: due 3000, ten-cycle pulse
        set_ch(0, 2000, 10);
        set_tm(900);
        clr_obs();
        strobe(0, 1000);
        run(2200);
        check_val("a_hi", 64'(hi_cnt[0]), 64'd10);
        check_val("a_rises", 64'(rises[0]), 64'd1);

        // due lands after the second wrap
        set_ch(1, 100, 3);
        set_tm(124999900);
        clr_obs();
        strobe(1, 124999950);
        run(250);
        check_val("b_hi", 64'(hi_cnt[1]), 64'd3);
        check_val("b_rises", 64'(rises[1]), 64'd1);

        // FIFO overflow on channel 2
        set_ch(2, 0, 2);
        set_tm(5000);
        clr_obs();
        for (int i = 0; i < 17; i++) strobe(2, 5200 + i * 4);
        run(2);
        check_val("c_full", 64'(fifo_full[2]), 64'd1);
        run(300);
        check_val("c_rises", 64'(rises[2]), 64'd16);

        // late entry and entry expiring while time is invalid
        set_ch(0, 0, 4);
        set_tm(600);
        clr_obs();
        strobe(0, 500);
        run(10);
        strobe(0, cur_tm + 20);
        tm_valid = 1'b0;
        run(40);
        tm_valid = 1'b1;
        run(5);
        check_val("d_rises", 64'(rises[0]), 64'd0);

        // retrigger extends the pulse
        set_ch(3, 0, 20);
        set_tm(7000);
        clr_obs();
        strobe(3, 7050);
        strobe(3, 7055);
        run(100);
        check_val("e_hi", 64'(hi_cnt[3]), 64'd25);
        check_val("e_rises", 64'(rises[3]), 64'd1);

        // disable flushes queue and truncates active pulse
        set_ch(0, 0, 50);
        set_tm(8000);
        strobe(0, 8010);
        strobe(0, 8100);
        strobe(0, 8110);
        strobe(0, 8120);
        run(15);
        clr_obs();
        enable[0] = 1'b0;
        step();
        check_val("f_off", 64'(pulse[0]), 64'd0);
        enable[0] = 1'b1;
        run(200);
        check_val("f_rises", 64'(rises[0]), 64'd0);
        check_val("f_hi", 64'(hi_cnt[0]), 64'd0);

        // random traffic around the second wrap
        set_tm(M - 2000);
        for (int k = 0; k < 4000; k++) begin
            if (k % 500 == 0) begin
                for (int c = 0; c < NCH; c++) set_ch(c, $urandom_range(0, 80), $urandom_range(0, 7));
            end
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 199) == 0) enable[c] = ~enable[c];
            end
            if (!tm_valid) tm_valid = ($urandom_range(0, 9) == 0);
            else tm_valid = ($urandom_range(0, 99) != 0);
            stat_clr = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 9) < 3) begin
                trig_valid = 1'b1;
                trig_ch = 2'($urandom_range(0, 3));
                trig_cycles = CB'((cur_tm + M - 20 + $urandom_range(0, 100)) % M);
            end
            step();
        end
        rst = 1'b0;
        stat_clr = 1'b0;
        tm_valid = 1'b1;
        enable = '1;
        run(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
